adder_pipe: RTL and testbench

Parametrised, pipelined integer adder/subtractor producing ARM64-style NZCV flags. A WIDTH-bit operation is split into STAGES equal slices. Each slice is a ripple of 1-bit full-adder cells, and the carry moves between slices through pipeline registers. The block sits in the EX stage as the wide-datapath ALU adder. It accepts one operation per cycle under a valid/ready handshake and returns results in order after a fixed latency.

---
 rtl/adder_pkg.sv | 37 +++
 rtl/adder_slice.sv | 31 +++
 rtl/adder_pipe.sv | 145 ++++++++++++++
 tb/tb_adder_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and helpers for the pipelined adder/subtractor.
//   op_t     - operation select (ADD, SUB, ADC, SBC)
//   flags_t  - ARM64-style NZCV flag bundle
//   eff_cin  - effective carry into bit 0 for a given operation
//   inv_b    - whether operand B is bitwise inverted for a given operation
package adder_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    ADC = 2'b10,
    SBC = 2'b11
  } op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic eff_cin(op_t op, logic cin);
    logic r;
    case (op)
      ADD:     r = 1'b0;
      SUB:     r = 1'b1;
      default: r = cin;
    endcase
    return r;
  endfunction

  // SUB and SBC add the one's complement of B.
  function automatic logic inv_b(op_t op);
    return (op == SUB) || (op == SBC);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational ripple of SW one-bit full-adder cells.
//   a, b  - slice operands (b already inverted for subtraction)
//   cin   - carry into bit 0 of the slice
//   sum   - slice result
//   cout  - carry out of the slice MSB
//   cmsb  - carry into the slice MSB (used for signed overflow)
module adder_slice #(
  parameter int unsigned SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  always_comb begin
    logic c;
    c    = cin;
    sum  = '0;
    cmsb = 1'b0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (i == SW - 1) cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit adder/subtractor with NZCV flags.
// The operation is split into STAGES slices of SW bits; the carry moves
// between slices through pipeline registers.
//   clk, reset_n          - rising-edge clock, async active-low reset
//   in_valid / in_ready   - input handshake
//   a, b, op, cin         - operands, operation, carry flag (ADC/SBC only)
//   out_valid / out_ready - output handshake
//   sum, flags            - result and {N,Z,C,V}
// Latency is STAGES-1 edges after the accepting edge; a single global stall
// freezes every stage while the output is held.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int unsigned SW = WIDTH / STAGES;

  logic             stall;
  logic             last_valid;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  flags_t           fl;

  assign b_eff     = inv_b(op) ? ~b : b;
  assign cin_eff   = eff_cin(op, cin);
  assign stall     = last_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = last_valid;

  // Stage k adds slice k of whatever operand bits are still pending (rem_*),
  // then registers the accumulated low result bits together with the
  // not-yet-added upper operand bits. Operands therefore shrink and the
  // result grows by SW bits per stage, which gives both skew and deskew.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-k*SW-1:0] rem_a;
    logic [WIDTH-k*SW-1:0] rem_b;
    logic                  c_in;
    logic                  z_in;
    logic                  v_in;
    logic [SW-1:0]         s;
    logic                  co;
    logic                  cm;
    logic                  z_all;
    logic [(k+1)*SW-1:0]   s_all;
    logic [(k+1)*SW-1:0]   s_q;
    logic                  v_q;
    logic                  c_q;
    logic                  z_q;

    if (k == 0) begin : g_head
      assign rem_a = a;
      assign rem_b = b_eff;
      assign c_in  = cin_eff;
      assign z_in  = 1'b1;
      assign v_in  = in_valid;
      assign s_all = s;
    end else begin : g_tail
      assign rem_a = g_st[k-1].g_skew.a_q;
      assign rem_b = g_st[k-1].g_skew.b_q;
      assign c_in  = g_st[k-1].c_q;
      assign z_in  = g_st[k-1].z_q;
      assign v_in  = g_st[k-1].v_q;
      assign s_all = {s, g_st[k-1].s_q};
    end

    adder_slice #(.SW(SW)) u_slice (
      .a    (rem_a[SW-1:0]),
      .b    (rem_b[SW-1:0]),
      .cin  (c_in),
      .sum  (s),
      .cout (co),
      .cmsb (cm)
    );

    assign z_all = z_in & (s == '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        z_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_in;
        c_q <= co;
        z_q <= z_all;
        s_q <= s_all;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-(k+1)*SW-1:0] a_q;
      logic [WIDTH-(k+1)*SW-1:0] b_q;
      logic                      cm_unused;

      // Only the final slice's MSB carry-in matters for V.
      assign cm_unused = cm;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= rem_a[WIDTH-k*SW-1:SW];
          b_q <= rem_b[WIDTH-k*SW-1:SW];
        end
      end
    end else begin : g_last
      logic ov_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ov_q <= 1'b0;
        end else if (!stall) begin
          ov_q <= co ^ cm;
        end
      end
    end
  end

  assign last_valid = g_st[STAGES-1].v_q;
  assign sum        = g_st[STAGES-1].s_q;

  assign fl.n  = g_st[STAGES-1].s_q[WIDTH-1];
  assign fl.z  = g_st[STAGES-1].z_q;
  assign fl.c  = g_st[STAGES-1].c_q;
  assign fl.v  = g_st[STAGES-1].g_last.ov_q;
  assign flags = fl;

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: self-checking bench for adder_pipe (WIDTH=64, STAGES=4).
// A queue-based reference model tracks every accepted operation with its
// full-width arithmetic result and the number of unstalled edges left
// before it must appear at the output.
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int W = 64;
  localparam int S = 4;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  op_t          op;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic [3:0]   flags;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain wide arithmetic reference: returns {sum, N, Z, C, V}.
  function automatic logic [67:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input op_t o, input logic ci);
    logic [63:0] yy;
    logic        c0;
    logic [64:0] full;
    logic        n, z, c, v;
    case (o)
      ADD:     begin yy = y;  c0 = 1'b0; end
      SUB:     begin yy = ~y; c0 = 1'b1; end
      ADC:     begin yy = y;  c0 = ci;   end
      default: begin yy = ~y; c0 = ci;   end
    endcase
    full = {1'b0, x} + {1'b0, yy} + {64'd0, c0};
    n = full[63];
    z = (full[63:0] == 64'd0);
    c = full[64];
    v = (x[63] == yy[63]) && (full[63] != x[63]);
    return {full[63:0], n, z, c, v};
  endfunction

  typedef struct {
    logic [67:0] res;
    int          rem;
  } ent_t;

  ent_t         q[$];
  logic [63:0]  got[$];
  logic         exp_ov;

  // Single compare process: sampled on the falling edge, away from the
  // active edge, then advances the model to the following rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_out_valid", {67'd0, out_valid}, 68'd0);
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (q[0].rem == 0);
      chk("out_valid", {67'd0, out_valid}, {67'd0, exp_ov});
      chk("in_ready", {67'd0, in_ready}, {67'd0, !(exp_ov && !out_ready)});
      if (exp_ov) begin
        chk("result", {sum, flags}, q[0].res);
      end
      if (!(exp_ov && !out_ready)) begin
        if (exp_ov && out_ready) begin
          got.push_back(q[0].res[67:4]);
          void'(q.pop_front());
        end
        foreach (q[i]) if (q[i].rem > 0) q[i].rem--;
        if (in_valid) q.push_back('{res: model(a, b, op, cin), rem: S - 1});
      end
    end
  end

  // Offer one operation starting now (posedge+2) and hold it until taken.
  task automatic send(input logic [63:0] x, input logic [63:0] y, input op_t o, input logic ci);
    bit ok;
    int guard;
    in_valid = 1'b1;
    a = x; b = y; op = o; cin = ci;
    ok = 1'b0;
    guard = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
      guard++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end
  endtask

  // Counts rising edges until out_valid is seen; returns realigned to posedge+2.
  task automatic wait_result(output int n, output logic [63:0] s_o, output logic [3:0] f_o);
    bit seen;
    n = 0;
    seen = 1'b0;
    s_o = '0;
    f_o = '0;
    while (!seen && n < 50) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        s_o = sum;
        f_o = flags;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: out_valid still 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run_dir(input string name, input logic [63:0] x, input logic [63:0] y,
                         input op_t o, input logic ci,
                         input logic [63:0] exp_s, input logic [3:0] exp_f);
    int          n;
    logic [63:0] s_o;
    logic [3:0]  f_o;
    chk({name, "_model"}, model(x, y, o, ci), {exp_s, exp_f});
    send(x, y, o, ci);
    in_valid = 1'b0;
    wait_result(n, s_o, f_o);
    chk({name, "_sum"}, {4'd0, s_o}, {4'd0, exp_s});
    chk({name, "_flags"}, {64'd0, f_o}, {64'd0, exp_f});
    chk({name, "_latency"}, n, S - 1);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    case ($urandom_range(0, 7))
      0:       r = 64'd0;
      1:       r = '1;
      2:       r = 64'h8000_0000_0000_0000;
      3:       r = 64'h7FFF_FFFF_FFFF_FFFF;
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #2;
    chk("drain_empty", q.size(), 0);
  endtask

  bit rnd_done;

  initial begin
    clk       = 1'b0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = ADD;
    cin       = 1'b0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;

    #1;
    chk("reset_out_valid", {67'd0, out_valid}, 68'd0);
    chk("reset_in_ready", {67'd0, in_ready}, 68'd1);
    chk("reset_sum_flags", {sum, flags}, 68'd0);
    #21 reset_n = 1'b1;
    @(posedge clk);
    #2;

    run_dir("add_1_1", 64'd1, 64'd1, ADD, 1'b0, 64'd2, 4'b0000);
    run_dir("add_carry_all", '1, 64'd1, ADD, 1'b0, 64'd0, 4'b0110);
    run_dir("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, SUB, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    run_dir("sbc_5_5", 64'd5, 64'd5, SBC, 1'b0, '1, 4'b1000);
    run_dir("adc_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, ADC, 1'b1,
            64'h8000_0000_0000_0000, 4'b1001);

    // Back-to-back stream with a 3-cycle output stall in the middle.
    got.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(64'(i), 64'd100, ADD, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("bp_order", {4'd0, got[i]}, 68'(100 + i));
    end

    // Randomized operations, gaps and backpressure.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #2;
          end
          send(rnd64(), rnd64(), op_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with operations in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(64'(10 + i), 64'd1, ADD, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", {67'd0, out_valid}, 68'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {67'd0, out_valid}, 68'd0);
    chk("async_rst_sum_flags", {sum, flags}, 68'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    run_dir("post_rst_add", 64'd2, 64'd3, ADD, 1'b0, 64'd5, 4'b0000);
    repeat (10) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1);
  end

endmodule
